// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
package regfile_pkg;

  localparam int DEF_N  = 8;
  localparam int DEF_AW = 3;

  // Register 0 is the hardwired-zero register.
  localparam int unsigned ZERO_REG = 0;

  typedef logic [DEF_AW-1:0] reg_addr_t;
  typedef logic [DEF_N-1:0]  reg_data_t;

endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register pending-write scoreboard: reserve sets, write releases, and a
// registered population count of the busy bits.
module regfile_busy_tracker
  import regfile_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we3,
  input  logic [AW-1:0]     wa3,
  input  logic              rsv,
  input  logic [AW-1:0]     rsv_a,
  output logic [2**AW-1:0]  busy,
  output logic [AW:0]       busy_cnt
);

  localparam int DEPTH = 2**AW;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [AW:0]      r_cnt;
  logic [AW:0]      w_cnt_nxt;

  // Release first, then reserve, so a same-address collision leaves the bit set.
  always_comb begin
    w_busy_nxt = r_busy;
    if (we3 && (wa3 != AW'(ZERO_REG))) w_busy_nxt[wa3] = 1'b0;
    if (rsv && (rsv_a != AW'(ZERO_REG))) w_busy_nxt[rsv_a] = 1'b1;
    w_busy_nxt[ZERO_REG] = 1'b0;
    w_cnt_nxt = '0;
    for (int i = 1; i < DEPTH; i++) begin
      w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_busy_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign busy     = r_busy;
  assign busy_cnt = r_cnt;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with two async read ports, one sync write port and a busy
// scoreboard. Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [N-1:0]  rd1,
  output logic [N-1:0]  rd2,
  output logic          rdy1,
  output logic          rdy2,
  input  logic          we3,
  input  logic [AW-1:0] wa3,
  input  logic [N-1:0]  wd3,
  input  logic          rsv,
  input  logic [AW-1:0] rsv_a,
  output logic [AW:0]   busy_cnt
);

  localparam int DEPTH = 2**AW;

  // Strobe semantics: we3 and rsv are single-cycle qualifiers sampled at the
  // posedge with no back-pressure; consumers must hold a read until rdyX=1.
  logic [N-1:0]     r_mem [DEPTH];
  logic [DEPTH-1:0] w_busy;
  logic             w_wr_hit;
  logic [N-1:0]     w_rd1;
  logic [N-1:0]     w_rd2;
  logic             w_rdy1;
  logic             w_rdy2;

  regfile_busy_tracker #(.AW(AW)) u_busy (
    .clk      (clk),
    .rst      (rst),
    .we3      (we3),
    .wa3      (wa3),
    .rsv      (rsv),
    .rsv_a    (rsv_a),
    .busy     (w_busy),
    .busy_cnt (busy_cnt)
  );

  assign w_wr_hit = we3 && (wa3 != AW'(ZERO_REG));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_hit) begin
      r_mem[wa3] <= wd3;
    end
  end

  always_comb begin
    w_rd1  = (ra1 == AW'(ZERO_REG)) ? '0 : r_mem[ra1];
    w_rd2  = (ra2 == AW'(ZERO_REG)) ? '0 : r_mem[ra2];
    w_rdy1 = ~w_busy[ra1];
    w_rdy2 = ~w_busy[ra2];
`ifdef REGFILE_BYPASS_EN
    // A same-cycle reserve of the written register keeps it not-ready.
    if (w_wr_hit && (ra1 == wa3)) begin
      w_rd1  = wd3;
      w_rdy1 = ~(rsv && (rsv_a == wa3));
    end
    if (w_wr_hit && (ra2 == wa3)) begin
      w_rd2  = wd3;
      w_rdy2 = ~(rsv && (rsv_a == wa3));
    end
`endif
  end

  assign rd1  = w_rd1;
  assign rd2  = w_rd2;
  assign rdy1 = w_rdy1;
  assign rdy2 = w_rdy2;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (N=8, AW=3).
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  reg_addr_t ra1, ra2, wa3, rsv_a;
  reg_data_t rd1, rd2, wd3;
  logic      rdy1, rdy2, we3, rsv;
  logic [3:0] busy_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  regfile_scoreboard #(.N(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .rdy1(rdy1), .rdy2(rdy2), .we3(we3), .wa3(wa3), .wd3(wd3),
    .rsv(rsv), .rsv_a(rsv_a), .busy_cnt(busy_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given write/reserve strobes, then idle the strobes.
  task automatic cycle(input logic we, input reg_addr_t wa, input reg_data_t wd,
                       input logic rv, input reg_addr_t rva);
    we3 = we; wa3 = wa; wd3 = wd; rsv = rv; rsv_a = rva;
    @(posedge clk); #1;
    we3 = 1'b0; rsv = 1'b0;
  endtask

  task automatic write_reg(input reg_addr_t wa, input reg_data_t wd);
    cycle(1'b1, wa, wd, 1'b0, 3'd0);
  endtask

  task automatic reserve(input reg_addr_t a);
    cycle(1'b0, 3'd0, 8'h00, 1'b1, a);
  endtask

  task automatic set_ra(input reg_addr_t a1, input reg_addr_t a2);
    ra1 = a1; ra2 = a2; #1;
  endtask

  initial begin
    // Reset
    rst = 1'b1; we3 = 1'b0; wa3 = '0; wd3 = '0; rsv = 1'b0; rsv_a = '0;
    ra1 = '0; ra2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    set_ra(3'd3, 3'd7);
    check("reset_rd1", rd1, 8'h00);
    check("reset_rdy2", rdy2, 1'b1);
    check("reset_cnt", busy_cnt, 4'd0);

    // Write then reset pulse clears it
    write_reg(3'd3, 8'h55);
    check("wr_r3", rd1, 8'h55);
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0; #1;
    check("rst_r3_rd1", rd1, 8'h00);
    check("rst_r3_rdy1", rdy1, 1'b1);
    check("rst_r3_cnt", busy_cnt, 4'd0);

    // Write/read and zero register
    write_reg(3'd5, 8'hA7);
    set_ra(3'd0, 3'd5);
    check("rd2_r5", rd2, 8'hA7);
    write_reg(3'd0, 8'hFF);
    check("rd1_r0", rd1, 8'h00);
    check("rdy1_r0", rdy1, 1'b1);
    check("cnt_after_w0", busy_cnt, 4'd0);

    // Reserve then release
    reserve(3'd4);
    set_ra(3'd4, 3'd0);
    check("rsv4_rdy1", rdy1, 1'b0);
    check("rsv4_cnt", busy_cnt, 4'd1);
    check("rsv4_rdy2_r0", rdy2, 1'b1);
    reserve(3'd0);
    check("rsv0_cnt", busy_cnt, 4'd1);
    write_reg(3'd4, 8'h3C);
    check("rel4_rdy1", rdy1, 1'b1);
    check("rel4_cnt", busy_cnt, 4'd0);
    check("rel4_rd1", rd1, 8'h3C);

    // Same-address collision: reserve wins, data written
    cycle(1'b1, 3'd2, 8'h11, 1'b1, 3'd2);
    set_ra(3'd2, 3'd2);
    check("coll_rd1", rd1, 8'h11);
    check("coll_rdy1", rdy1, 1'b0);
    check("coll_cnt", busy_cnt, 4'd1);
    check("coll_rd2", rd2, 8'h11);
    check("coll_rdy2", rdy2, 1'b0);
    write_reg(3'd2, 8'h22);
    check("coll_rel_cnt", busy_cnt, 4'd0);
    check("coll_rel_rdy1", rdy1, 1'b1);

    // Different-address write and reserve in one cycle
    reserve(3'd5);
    check("r5_cnt", busy_cnt, 4'd1);
    cycle(1'b1, 3'd5, 8'h44, 1'b1, 3'd3);
    set_ra(3'd5, 3'd3);
    check("diff_rdy1", rdy1, 1'b1);
    check("diff_rdy2", rdy2, 1'b0);
    check("diff_rd1", rd1, 8'h44);
    check("diff_cnt", busy_cnt, 4'd1);
    write_reg(3'd3, 8'h33);
    check("diff_rel_cnt", busy_cnt, 4'd0);

    // Bypass behaviour, sampled combinationally before the edge
    write_reg(3'd6, 8'h10);
    set_ra(3'd6, 3'd1);
    we3 = 1'b1; wa3 = 3'd6; wd3 = 8'h99; #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_rd1", rd1, 8'h99);
`else
    check("byp_rd1", rd1, 8'h10);
`endif
    check("byp_rdy1", rdy1, 1'b1);
    rsv = 1'b1; rsv_a = 3'd6; #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_rsv_rdy1", rdy1, 1'b0);
`else
    check("byp_rsv_rdy1", rdy1, 1'b1);
`endif
    @(posedge clk); #1;
    we3 = 1'b0; rsv = 1'b0; #1;
    check("byp_post_rd1", rd1, 8'h99);
    check("byp_post_cnt", busy_cnt, 4'd1);
    write_reg(3'd6, 8'h66);
    check("byp_rel_cnt", busy_cnt, 4'd0);

    // Readback sweep through the expected queue
    for (int i = 1; i < 8; i++) begin
      reg_data_t v;
      v = reg_data_t'(8'h20 + 8'(i * 17));
      write_reg(reg_addr_t'(i), v);
      exp_q.push_back(v);
    end
    for (int i = 1; i < 8; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      set_ra(reg_addr_t'(i), reg_addr_t'(i));
      check($sformatf("sweep_rd1_r%0d", i), rd1, e);
      check($sformatf("sweep_rd2_r%0d", i), rd2, e);
    end

    // Saturation and mid-operation reset
    for (int i = 1; i < 8; i++) reserve(reg_addr_t'(i));
    check("sat_cnt", busy_cnt, 4'd7);
    reserve(3'd7);
    check("sat_again_cnt", busy_cnt, 4'd7);
    set_ra(3'd1, 3'd7);
    check("sat_rdy1", rdy1, 1'b0);
    rst = 1'b1;
    cycle(1'b1, 3'd1, 8'hEE, 1'b1, 3'd2);
    rst = 1'b0; #1;
    check("midrst_cnt", busy_cnt, 4'd0);
    check("midrst_rd1", rd1, 8'h00);
    check("midrst_rdy1", rdy1, 1'b1);
    check("midrst_rd2", rd2, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
